// File: rtl/bus_arb_pkg.sv
// Shared constants, FSM state encoding and width helper for the bus arbitrating mux.
package bus_arb_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Ceiling log2, never below 1 so a select field always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner search: lowest index from 0 (fixed) or from start_idx with wrap (round-robin).
module bus_arb_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    localparam int unsigned SEL_W = clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [SEL_W-1:0]       start_idx,
    input  logic                   rr_mode,
    output logic [SEL_W-1:0]       winner_idx_c,
    output logic                   found_c
);

    // Scan from the far end so the candidate closest to the start is the last one kept.
    always_comb begin
        int pos;
        int base;
        pos          = 0;
        base         = rr_mode ? int'(start_idx) : 0;
        winner_idx_c = '0;
        found_c      = 1'b0;
        for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
            pos = base + i;
            if (pos >= int'(NUM_MASTERS)) pos = pos - int'(NUM_MASTERS);
            if (req[SEL_W'(pos)]) begin
                winner_idx_c = SEL_W'(pos);
                found_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// N-master arbitrating bus mux: holds a grant until the owner finishes, registers owner data onto the bus.
// Optional grant-length limit enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arb_mux
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DATA_BITWIDTH  = 32,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned SEL_W = clog2(NUM_MASTERS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_MASTERS-1:0]             req,
    input  logic [NUM_MASTERS-1:0]             done,
    input  logic [NUM_MASTERS*DATA_BITWIDTH-1:0] data_in,
    output logic [NUM_MASTERS-1:0]             grant,
    output logic                               grant_valid,
    output logic [SEL_W-1:0]                   grant_idx,
    output logic [DATA_BITWIDTH-1:0]           bus_out,
    output logic                               bus_valid,
    output logic                               timeout
);

    state_e                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic                     grant_valid_q, grant_valid_d;
    logic [SEL_W-1:0]         grant_idx_q, grant_idx_d;
    logic [SEL_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [DATA_BITWIDTH-1:0] bus_out_q, bus_out_d;
    logic                     bus_valid_q, bus_valid_d;

    logic [SEL_W-1:0] start_idx_c;
    logic [SEL_W-1:0] winner_idx_c;
    logic             found_c;
    logic             natural_rel_c;
    logic             timeout_hit_c;

    assign start_idx_c   = (rr_ptr_q == SEL_W'(NUM_MASTERS - 1)) ? '0 : rr_ptr_q + 1'b1;
    assign natural_rel_c = done[grant_idx_q] | ~req[grant_idx_q];

    bus_arb_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req          (req),
        .start_idx    (start_idx_c),
        .rr_mode      (ARB_MODE == ARB_RR),
        .winner_idx_c (winner_idx_c),
        .found_c      (found_c)
    );

    // Next-state, grant and bus data; IDLE always lasts at least one cycle after a release.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        rr_ptr_d      = rr_ptr_q;
        bus_out_d     = '0;
        bus_valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    state_d               = ST_GRANT;
                    grant_d               = '0;
                    grant_d[winner_idx_c] = 1'b1;
                    grant_valid_d         = 1'b1;
                    grant_idx_d           = winner_idx_c;
                    rr_ptr_d              = winner_idx_c;
                end
            end
            ST_GRANT: begin
                bus_out_d   = data_in[int'(grant_idx_q)*DATA_BITWIDTH +: DATA_BITWIDTH];
                bus_valid_d = 1'b1;
                if (natural_rel_c || timeout_hit_c) begin
                    state_d       = ST_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_idx_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= SEL_W'(NUM_MASTERS - 1);
            bus_out_q     <= '0;
            bus_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            bus_out_q     <= bus_out_d;
            bus_valid_q   <= bus_valid_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign timeout_hit_c = (state_q == ST_GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts completed GRANT cycles; a pulse only when the limit, not the owner, ends the grant.
    always_comb begin
        cnt_d     = (state_q == ST_GRANT) ? cnt_q + 1'b1 : '0;
        timeout_d = timeout_hit_c && !natural_rel_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit_c = 1'b0;
    assign timeout       = 1'b0;
`endif

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign bus_out     = bus_out_q;
    assign bus_valid   = bus_valid_q;

endmodule
